gate_response_checker: RTL and testbench

Self-checking response monitor for the basic-gate benches. It consumes the per-clock random stimulus (A, B) that drives a two-input gate under test, and the gate's three outputs (X, Y, Z). It compares those outputs against the NAND reference after a configurable pipeline latency, and accumulates vector, error and coverage statistics. The bench asserts `start`, waits for `done`, then reads `pass` and the counters, so no waveform inspection is needed.

---
 rtl/gate_response_checker.sv | 144 ++++++++++++++
 tb/tb_gate_response_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// gate_response_checker: checks x/y/z against NAND of a,b delayed by LATENCY and keeps run statistics.
// Optional coverage outputs (cov_mask, all_covered) are built when GATE_CHECKER_COVERAGE_EN is defined.
module gate_response_checker #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 10,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
`ifdef GATE_CHECKER_COVERAGE_EN
  output logic [3:0]       cov_mask,
  output logic             all_covered,
`endif
  output logic [CNT_W-1:0] first_err_vec
);

  localparam int unsigned       DL_D      = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned       DL_W      = 2 * DL_D;
  localparam int unsigned       FILL_W    = 3;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam logic [CNT_W-1:0]  LAST_VEC  = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t            state, state_next;
  logic [DL_W-1:0]   dl, dl_next;
  logic [FILL_W-1:0] fill_cnt, fill_next;
  logic [CNT_W-1:0]  vec_next, err_next, first_next;
  logic              busy_next, done_next, pass_next, mis_next;
  logic [1:0]        tap_c;
  logic              exp_c, fail_c;
`ifdef GATE_CHECKER_COVERAGE_EN
  logic [3:0]        cov_next;
`endif

  // Newest {a,b} sits in the low bits; the oldest entry is the compare tap.
  always_comb begin
    tap_c  = (LATENCY == 0) ? {a, b} : dl[DL_W-1 -: 2];
    exp_c  = ~(tap_c[1] & tap_c[0]);
    fail_c = (x !== exp_c) || (y !== exp_c) || (z !== exp_c);
  end

  always_comb begin
    state_next = state;
    dl_next    = dl;
    fill_next  = fill_cnt;
    vec_next   = vec_count;
    err_next   = err_count;
    first_next = first_err_vec;
    pass_next  = pass;
    mis_next   = 1'b0;
`ifdef GATE_CHECKER_COVERAGE_EN
    cov_next   = cov_mask;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (LATENCY == 0) ? CHECK : FILL;
          dl_next    = '0;
          fill_next  = '0;
          vec_next   = '0;
          err_next   = '0;
          first_next = '0;
          pass_next  = 1'b0;
`ifdef GATE_CHECKER_COVERAGE_EN
          cov_next   = '0;
`endif
        end
      end
      FILL: begin
        dl_next = DL_W'({dl, a, b});
        if (fill_cnt == FILL_LAST) state_next = CHECK;
        else                       fill_next  = fill_cnt + FILL_W'(1);
      end
      CHECK: begin
        dl_next  = DL_W'({dl, a, b});
        vec_next = vec_count + CNT_W'(1);
        if (fail_c) begin
          mis_next = 1'b1;
          if (err_count != CNT_MAX) err_next   = err_count + CNT_W'(1);
          if (err_count == '0)      first_next = vec_count;
        end
`ifdef GATE_CHECKER_COVERAGE_EN
        cov_next[tap_c] = 1'b1;
`endif
        if (vec_count == LAST_VEC) begin
          state_next = DONE;
          pass_next  = (err_next == '0);
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == FILL) || (state_next == CHECK);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dl            <= '0;
      fill_cnt      <= '0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch      <= 1'b0;
`ifdef GATE_CHECKER_COVERAGE_EN
      cov_mask      <= '0;
      all_covered   <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      dl            <= dl_next;
      fill_cnt      <= fill_next;
      vec_count     <= vec_next;
      err_count     <= err_next;
      first_err_vec <= first_next;
      busy          <= busy_next;
      done          <= done_next;
      pass          <= pass_next;
      mismatch      <= mis_next;
`ifdef GATE_CHECKER_COVERAGE_EN
      cov_mask      <= cov_next;
      all_covered   <= &cov_next;
`endif
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a latency-1 instance with a registered NAND and a
// latency-0 narrow-counter instance with a combinational NAND, checked against run-level expectations.
module tb_gate_response_checker;

  localparam int unsigned L1 = 1;
  localparam int unsigned N1 = 10;
  localparam int unsigned W1 = 16;
  localparam int unsigned L0 = 0;
  localparam int unsigned N0 = 15;
  localparam int unsigned W0 = 4;

  logic clk = 1'b0;
  logic rst, a, b;
  always #5 clk = ~clk;

  logic          start1, x1, y1, z1, busy1, done1, pass1, mis1;
  logic [W1-1:0] vec1, err1, first1;
  logic          start0, x0, y0, z0, busy0, done0, pass0, mis0;
  logic [W0-1:0] vec0, err0, first0;
`ifdef GATE_CHECKER_COVERAGE_EN
  logic [3:0]    cov1, cov0;
  logic          allc1, allc0;
`endif

  int nvec = 0;
  int nerr = 0;

  // Gates under test: registered NAND with fault injection, and a combinational NAND.
  logic gq, f_y, f_all, stuck0;
  always @(posedge clk) gq <= ~(a & b);
  assign x1 = f_all ? ~gq : gq;
  assign y1 = (f_y || f_all) ? ~gq : gq;
  assign z1 = f_all ? ~gq : gq;
  assign x0 = stuck0 ? 1'b1 : ~(a & b);
  assign y0 = ~(a & b);
  assign z0 = ~(a & b);

  gate_response_checker #(.LATENCY(L1), .NUM_VECTORS(N1), .CNT_W(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch(mis1),
    .vec_count(vec1), .err_count(err1),
`ifdef GATE_CHECKER_COVERAGE_EN
    .cov_mask(cov1), .all_covered(allc1),
`endif
    .first_err_vec(first1)
  );

  gate_response_checker #(.LATENCY(L0), .NUM_VECTORS(N0), .CNT_W(W0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b), .x(x0), .y(y0), .z(z0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch(mis0),
    .vec_count(vec0), .err_count(err0),
`ifdef GATE_CHECKER_COVERAGE_EN
    .cov_mask(cov0), .all_covered(allc0),
`endif
    .first_err_vec(first0)
  );

  function automatic logic [1:0] pick(input int mode, input int j);
    case (mode)
      1:       return {1'b0, j[0]};
      2:       return 2'(j);
      default: return 2'($urandom);
    endcase
  endfunction

  task automatic check_idle1(input string tag);
    nvec++;
    if ({busy1, done1, pass1, mis1} !== 4'b0 || vec1 !== '0 || err1 !== '0 || first1 !== '0) begin
      nerr++;
      $display("FAIL %s: got busy=%b done=%b pass=%b mis=%b vec=%0d err=%0d first=%0d want all 0",
               tag, busy1, done1, pass1, mis1, vec1, err1, first1);
    end
`ifdef GATE_CHECKER_COVERAGE_EN
    nvec++;
    if (cov1 !== 4'b0 || allc1 !== 1'b0) begin
      nerr++;
      $display("FAIL %s_cov: got cov=%b allc=%b want 0", tag, cov1, allc1);
    end
`endif
  endtask

  // One run on dut1; fidx<0 means fault-free, abort_at>=0 resets once vec_count reaches it.
  task automatic run1(input int fidx, input bit fall, input int abmode, input bit pulse_mid,
                      input int abort_at, input string tag);
    logic [1:0] ab;
    logic [3:0] emask;
    int         evec, eerr, efirst;
    bit         emis;
    emask = 4'b0;
    @(negedge clk);
    start1 = 1'b1;
    {a, b} = 2'($urandom);
    f_y = 1'b0;
    f_all = 1'b0;
    @(posedge clk);
    for (int j = 0; j <= int'(L1 + N1); j++) begin
      @(negedge clk);
      evec   = (j <= int'(L1)) ? 0 : ((j - int'(L1) > int'(N1)) ? int'(N1) : j - int'(L1));
      emis   = (fidx >= 0) && (j - int'(L1) - 1 == fidx);
      eerr   = ((fidx >= 0) && (j - int'(L1) - 1 >= fidx)) ? 1 : 0;
      efirst = (eerr != 0) ? fidx : 0;
      nvec++;
      if (busy1 !== (j < int'(L1 + N1)) || done1 !== (j >= int'(L1 + N1))) begin
        nerr++;
        $display("FAIL %s_flags j=%0d: got busy=%b done=%b", tag, j, busy1, done1);
      end
      nvec++;
      if (vec1 !== W1'(evec)) begin
        nerr++;
        $display("FAIL %s_vec j=%0d: got %0d want %0d", tag, j, vec1, evec);
      end
      nvec++;
      if (mis1 !== emis) begin
        nerr++;
        $display("FAIL %s_mismatch j=%0d: got %b want %b", tag, j, mis1, emis);
      end
      nvec++;
      if (err1 !== W1'(eerr) || first1 !== W1'(efirst)) begin
        nerr++;
        $display("FAIL %s_err j=%0d: got err=%0d first=%0d want err=%0d first=%0d",
                 tag, j, err1, first1, eerr, efirst);
      end
      if (abort_at >= 0 && j == int'(L1) + abort_at) begin
        rst = 1'b1;
        #1;
        check_idle1({tag, "_async_rst"});
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      start1 = pulse_mid && (j == 3);
      ab = pick(abmode, j);
      {a, b} = ab;
      if (j < int'(N1)) emask[ab] = 1'b1;
      f_y   = !fall && (j - int'(L1) == fidx);
      f_all =  fall && (j - int'(L1) == fidx);
      @(posedge clk);
    end
    @(negedge clk);
    eerr   = (fidx >= 0 && fidx < int'(N1)) ? 1 : 0;
    efirst = (eerr != 0) ? fidx : 0;
    nvec++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== (eerr == 0)) begin
      nerr++;
      $display("FAIL %s_final_flags: got done=%b busy=%b pass=%b want 1 0 %b",
               tag, done1, busy1, pass1, eerr == 0);
    end
    nvec++;
    if (vec1 !== W1'(N1) || err1 !== W1'(eerr) || first1 !== W1'(efirst)) begin
      nerr++;
      $display("FAIL %s_final_counts: got vec=%0d err=%0d first=%0d want %0d %0d %0d",
               tag, vec1, err1, first1, N1, eerr, efirst);
    end
`ifdef GATE_CHECKER_COVERAGE_EN
    nvec++;
    if (cov1 !== emask || allc1 !== (&emask)) begin
      nerr++;
      $display("FAIL %s_cov: got cov=%b allc=%b want cov=%b allc=%b", tag, cov1, allc1, emask, &emask);
    end
`endif
  endtask

  // One run on dut0 (latency 0); stuck drives x=1 with a=b=1 on every vector.
  task automatic run0(input bit stuck, input string tag);
    int ecnt, eerr;
    @(negedge clk);
    start0 = 1'b1;
    stuck0 = stuck;
    {a, b} = stuck ? 2'b11 : 2'($urandom);
    @(posedge clk);
    for (int j = 0; j <= int'(N0); j++) begin
      @(negedge clk);
      ecnt = (j > int'(N0)) ? int'(N0) : j;
      eerr = stuck ? ecnt : 0;
      nvec++;
      if (busy0 !== (j < int'(N0)) || done0 !== (j >= int'(N0))) begin
        nerr++;
        $display("FAIL %s_flags j=%0d: got busy=%b done=%b", tag, j, busy0, done0);
      end
      nvec++;
      if (vec0 !== W0'(ecnt) || err0 !== W0'(eerr)) begin
        nerr++;
        $display("FAIL %s_counts j=%0d: got vec=%0d err=%0d want %0d %0d", tag, j, vec0, err0, ecnt, eerr);
      end
      nvec++;
      if (mis0 !== (stuck && j >= 1 && j <= int'(N0))) begin
        nerr++;
        $display("FAIL %s_mismatch j=%0d: got %b want %b", tag, j, mis0, stuck && j >= 1);
      end
      start0 = 1'b0;
      {a, b} = stuck ? 2'b11 : 2'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    nvec++;
    if (done0 !== 1'b1 || pass0 !== !stuck || vec0 !== W0'(N0) || err0 !== (stuck ? 4'hF : 4'h0)
        || first0 !== '0) begin
      nerr++;
      $display("FAIL %s_final: got done=%b pass=%b vec=%0d err=%0d first=%0d", tag, done0, pass0,
               vec0, err0, first0);
    end
    stuck0 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle1("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle1("reset_released");
    nvec++;
    if ({busy0, done0, pass0, mis0} !== 4'b0 || vec0 !== '0 || err0 !== '0) begin
      nerr++;
      $display("FAIL reset_dut0: got busy=%b done=%b pass=%b vec=%0d err=%0d want 0",
               busy0, done0, pass0, vec0, err0);
    end
  endtask

  task automatic test_clean();          run1(-1, 1'b0, 0, 1'b0, -1, "clean");        endtask
  task automatic test_single_fault();   run1(3,  1'b0, 0, 1'b0, -1, "single_fault"); endtask
  task automatic test_triple_fault();   run1(7,  1'b1, 0, 1'b0, -1, "triple_fault"); endtask
  task automatic test_start_while_busy(); run1(-1, 1'b0, 0, 1'b1, -1, "start_busy"); endtask

  task automatic test_reset_mid_run();
    run1(-1, 1'b0, 0, 1'b0, 4, "mid_rst");
    @(negedge clk);
    check_idle1("mid_rst_stays_idle");
    run1(-1, 1'b0, 0, 1'b0, -1, "after_rst");
  endtask

  task automatic test_latency0();   run0(1'b0, "lat0");       endtask
  task automatic test_saturation(); run0(1'b1, "saturation"); endtask

  task automatic test_back_to_back();
    run0(1'b0, "b2b_clean");
    run1(0, 1'b0, 0, 1'b0, -1, "b2b_fault0");
    run1(N1 - 1, 1'b0, 0, 1'b0, -1, "b2b_fault_last");
  endtask

  task automatic test_coverage();
    run1(-1, 1'b0, 1, 1'b0, -1, "cov_partial");
    run1(-1, 1'b0, 2, 1'b0, -1, "cov_full");
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    a = 1'b0;
    b = 1'b0;
    f_y = 1'b0;
    f_all = 1'b0;
    stuck0 = 1'b0;
    test_reset();
    test_clean();
    test_single_fault();
    test_triple_fault();
    test_start_while_busy();
    test_reset_mid_run();
    test_latency0();
    test_saturation();
    test_back_to_back();
    test_coverage();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
